// File: rtl/fmap_pkg.sv
// Shared types and helpers for the pooling feature-map buffer: FSM states,
// default geometry and the saturating bias-add used on every store.
package fmap_pkg;

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, WR, DONE} pool_state_e;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int NPIX      = IMG_W_DEF * IMG_H_DEF;
  localparam int OW        = IMG_W_DEF / 2;
  localparam int OH        = IMG_H_DEF / 2;

  // Operands arrive sign-extended to 32 bits; the result is clamped to a dw-bit signed range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int dw);
    logic signed [31:0] sum, hi, lo;
    sum = a + b;
    hi  = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo  = -hi - 32'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/fmap_bank.sv
// One channel of the feature map: DW x DEPTH block RAM with two registered read
// ports, one write port and the 2x2 window running max. Build macro: POOL_RELU_EN.
module fmap_bank
  import fmap_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = NPIX,
  parameter int AW    = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic                 re_a,
  input  logic [AW-1:0]        raddr_a,
  input  logic                 re_b,
  input  logic [AW-1:0]        raddr_b,
  input  logic                 max_ld,
  input  logic                 max_acc,
  output logic signed [DW-1:0] rdata_a,
  output logic signed [DW-1:0] rdata_b,
  output logic signed [DW-1:0] pool_val
);

  logic signed [DW-1:0] mem [DEPTH];
  logic signed [DW-1:0] run_max;
  logic signed [DW-1:0] win_max;

  // Read-first: a same-edge write is not visible on the read registers.
  always_ff @(posedge clk) begin
    if (we)   mem[waddr] <= wdata;
    if (re_a) rdata_a    <= mem[raddr_a];
    if (re_b) rdata_b    <= mem[raddr_b];
  end

  // Strict greater-than so a tie keeps the earlier pixel.
  always_ff @(posedge clk) begin
    if (max_ld)                           run_max <= rdata_a;
    else if (max_acc && rdata_a > run_max) run_max <= rdata_a;
  end

  always_comb begin
    win_max = (rdata_a > run_max) ? rdata_a : run_max;
`ifdef POOL_RELU_EN
    pool_val = win_max[DW-1] ? '0 : win_max;
`else
    pool_val = win_max;
`endif
  end

endmodule

// File: rtl/fmap_pool_buffer.sv
// Per-channel conv output buffer: saturating bias store, in-place 2x2/stride-2
// max-pool over all banks, dual-address read. Build macro: POOL_RELU_EN.
module fmap_pool_buffer
  import fmap_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int DW    = 8,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [$clog2(NCH)-1:0] wr_ch,
  input  logic [AW-1:0]          wr_addr,
  input  logic signed [DW-1:0]   wr_data,
  input  logic signed [DW-1:0]   wr_bias,
  input  logic                   pool_start,
  output logic                   pool_busy,
  output logic                   pool_done,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr_a,
  input  logic [AW-1:0]          rd_addr_b,
  output logic [NCH*DW-1:0]      rd_data_a,
  output logic [NCH*DW-1:0]      rd_data_b,
  output logic                   rd_valid
);

  localparam int PIX = IMG_W * IMG_H;
  localparam int PW  = IMG_W / 2;
  localparam int PH  = IMG_H / 2;

  pool_state_e          state, state_nx;
  logic [AW-1:0]        wr_row, wr_col, base, out_addr, pool_raddr, raddr_a;
  logic                 idle, acc_pool, acc_wr, acc_rd, wr_ok, last_win;
  logic                 pool_rd, pool_we, max_ld, max_acc, re_a;
  logic                 rd_ok_a, rd_ok_b;
  logic signed [DW-1:0] wr_sat;

  assign idle     = (state == IDLE);
  assign acc_pool = idle && pool_start;
  assign acc_wr   = idle && !pool_start && wr_en;
  assign acc_rd   = idle && !pool_start && !wr_en && rd_en;
  assign wr_ok    = (int'(wr_ch) < NCH) && (int'(wr_addr) < PIX);
  assign wr_sat   = DW'(sat_add(32'(wr_data), 32'(wr_bias), DW));

  assign base     = AW'(2 * IMG_W * int'(wr_row) + 2 * int'(wr_col));
  assign out_addr = AW'(PW * int'(wr_row) + int'(wr_col));
  assign last_win = (int'(wr_row) == PH - 1) && (int'(wr_col) == PW - 1);
  assign re_a     = acc_rd || pool_rd;
  assign raddr_a  = pool_rd ? pool_raddr : rd_addr_a;

  // Read data lags the address by one cycle, so the max is loaded in RD1 and
  // the fourth pixel is folded in combinationally during WR.
  always_comb begin
    state_nx   = state;
    pool_busy  = 1'b0;
    pool_done  = 1'b0;
    pool_rd    = 1'b0;
    pool_we    = 1'b0;
    max_ld     = 1'b0;
    max_acc    = 1'b0;
    pool_raddr = base;
    case (state)
      IDLE: if (pool_start) state_nx = RD0;
      RD0: begin
        pool_busy = 1'b1; pool_rd = 1'b1;
        state_nx  = RD1;
      end
      RD1: begin
        pool_busy = 1'b1; pool_rd = 1'b1; max_ld = 1'b1;
        pool_raddr = base + AW'(1);
        state_nx   = RD2;
      end
      RD2: begin
        pool_busy = 1'b1; pool_rd = 1'b1; max_acc = 1'b1;
        pool_raddr = base + AW'(IMG_W);
        state_nx   = RD3;
      end
      RD3: begin
        pool_busy = 1'b1; pool_rd = 1'b1; max_acc = 1'b1;
        pool_raddr = base + AW'(IMG_W + 1);
        state_nx   = WR;
      end
      WR: begin
        pool_busy = 1'b1; pool_we = 1'b1;
        state_nx  = last_win ? DONE : RD0;
      end
      DONE: begin
        pool_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_row   <= '0;
      wr_col   <= '0;
      rd_valid <= 1'b0;
      rd_ok_a  <= 1'b0;
      rd_ok_b  <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_valid <= acc_rd;
      if (acc_pool) begin
        wr_row  <= '0;
        wr_col  <= '0;
        rd_ok_a <= 1'b0;
        rd_ok_b <= 1'b0;
      end else if (state == WR) begin
        if (int'(wr_col) == PW - 1) begin
          wr_col <= '0;
          wr_row <= wr_row + AW'(1);
        end else begin
          wr_col <= wr_col + AW'(1);
        end
      end
      if (acc_rd) begin
        rd_ok_a <= (int'(rd_addr_a) < PIX);
        rd_ok_b <= (int'(rd_addr_b) < PIX);
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_bank
    logic                 we_k;
    logic signed [DW-1:0] q_a, q_b, pv;

    assign we_k = pool_we || (acc_wr && wr_ok && int'(wr_ch) == k);

    fmap_bank #(.DW(DW), .DEPTH(PIX), .AW(AW)) u_bank (
      .clk     (clk),
      .we      (we_k),
      .waddr   (pool_we ? out_addr : wr_addr),
      .wdata   (pool_we ? pv : wr_sat),
      .re_a    (re_a),
      .raddr_a (raddr_a),
      .re_b    (acc_rd),
      .raddr_b (rd_addr_b),
      .max_ld  (max_ld),
      .max_acc (max_acc),
      .rdata_a (q_a),
      .rdata_b (q_b),
      .pool_val(pv)
    );

    assign rd_data_a[k*DW +: DW] = rd_ok_a ? q_a : '0;
    assign rd_data_b[k*DW +: DW] = rd_ok_b ? q_b : '0;
  end

endmodule

// File: tb/tb_fmap_pool_buffer.sv
// Bench for fmap_pool_buffer: default 8ch 28x28 instance plus a 4ch 8x8 instance,
// checked against an array-based reference of store, read and pooling.
module tb_fmap_pool_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        b_wr_en, b_pool_start, b_pool_busy, b_pool_done, b_rd_en, b_rd_valid;
  logic [2:0]  b_wr_ch;
  logic [9:0]  b_wr_addr, b_rd_addr_a, b_rd_addr_b;
  logic signed [7:0] b_wr_data, b_wr_bias;
  logic [63:0] b_rd_data_a, b_rd_data_b;

  logic        s_wr_en, s_pool_start, s_pool_busy, s_pool_done, s_rd_en, s_rd_valid;
  logic [1:0]  s_wr_ch;
  logic [5:0]  s_wr_addr, s_rd_addr_a, s_rd_addr_b;
  logic signed [7:0] s_wr_data, s_wr_bias;
  logic [31:0] s_rd_data_a, s_rd_data_b;

  fmap_pool_buffer u_big (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_bias(b_wr_bias), .pool_start(b_pool_start),
    .pool_busy(b_pool_busy), .pool_done(b_pool_done), .rd_en(b_rd_en),
    .rd_addr_a(b_rd_addr_a), .rd_addr_b(b_rd_addr_b), .rd_data_a(b_rd_data_a),
    .rd_data_b(b_rd_data_b), .rd_valid(b_rd_valid)
  );

  fmap_pool_buffer #(.NCH(4), .DW(8), .IMG_W(8), .IMG_H(8), .AW(6)) u_small (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_ch(s_wr_ch), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .wr_bias(s_wr_bias), .pool_start(s_pool_start),
    .pool_busy(s_pool_busy), .pool_done(s_pool_done), .rd_en(s_rd_en),
    .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b), .rd_data_a(s_rd_data_a),
    .rd_data_b(s_rd_data_b), .rd_valid(s_rd_valid)
  );

`ifdef POOL_RELU_EN
  localparam logic [7:0] EXP_OUT0 = 8'h00;
  localparam logic [7:0] EXP_NEG5 = 8'h00;
`else
  localparam logic [7:0] EXP_OUT0 = 8'hEB;
  localparam logic [7:0] EXP_NEG5 = 8'hFB;
`endif

  int ncmp = 0;
  int nerr = 0;
  int refm [2][8][784];

  function automatic int sat8(int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int relu(int x);
`ifdef POOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [63:0] exp_vec(int id, int nch, int npix, int addr);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < nch; k++)
      if (addr < npix) v[k*8 +: 8] = 8'(refm[id][k][addr]);
    return v;
  endfunction

  // Pooling computed from a frozen pre-pool image; outside the pooled area data stays stale.
  task automatic model_pool(int id, int nch, int w, int h);
    int tmp [8][784];
    int m, b;
    tmp = refm[id];
    for (int k = 0; k < nch; k++)
      for (int r = 0; r < h / 2; r++)
        for (int c = 0; c < w / 2; c++) begin
          b = 2 * r * w + 2 * c;
          m = tmp[k][b];
          if (tmp[k][b + 1] > m) m = tmp[k][b + 1];
          if (tmp[k][b + w] > m) m = tmp[k][b + w];
          if (tmp[k][b + w + 1] > m) m = tmp[k][b + w + 1];
          refm[id][k][r * (w / 2) + c] = relu(m);
        end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_store(int ch, int addr, int d, int bias);
    b_wr_en = 1'b1; b_wr_ch = 3'(ch); b_wr_addr = 10'(addr);
    b_wr_data = 8'(d); b_wr_bias = 8'(bias);
    tick();
    b_wr_en = 1'b0;
    if (addr < 784) refm[0][ch][addr] = sat8(d + bias);
  endtask

  task automatic b_rd(int a, int b, string tag);
    b_rd_en = 1'b1; b_rd_addr_a = 10'(a); b_rd_addr_b = 10'(b);
    tick();
    b_rd_en = 1'b0;
    chk({tag, ".valid"}, 64'(b_rd_valid), 64'd1);
  endtask

  task automatic b_read_full(int a, int b, string tag);
    b_rd(a, b, tag);
    chk($sformatf("%s.a@%0d", tag, a), b_rd_data_a, exp_vec(0, 8, 784, a));
    chk($sformatf("%s.b@%0d", tag, b), b_rd_data_b, exp_vec(0, 8, 784, b));
  endtask

  task automatic s_store(int ch, int addr, int d, int bias);
    s_wr_en = 1'b1; s_wr_ch = 2'(ch); s_wr_addr = 6'(addr);
    s_wr_data = 8'(d); s_wr_bias = 8'(bias);
    tick();
    s_wr_en = 1'b0;
    refm[1][ch][addr] = sat8(d + bias);
  endtask

  task automatic s_read_full(int a, int b);
    s_rd_en = 1'b1; s_rd_addr_a = 6'(a); s_rd_addr_b = 6'(b);
    tick();
    s_rd_en = 1'b0;
    chk("s.valid", 64'(s_rd_valid), 64'd1);
    chk($sformatf("s.a@%0d", a), 64'(s_rd_data_a), exp_vec(1, 4, 64, a));
    chk($sformatf("s.b@%0d", b), 64'(s_rd_data_b), exp_vec(1, 4, 64, b));
  endtask

  // Pool on the big instance with a pool_start-vs-wr_en collision at start and
  // illegal strobes mid-pool; returns the edge count at which pool_done was seen.
  task automatic b_pool(output int cyc);
    b_pool_start = 1'b1;
    b_wr_en = 1'b1; b_wr_ch = 3'd0; b_wr_addr = 10'd700; b_wr_data = 8'sd77; b_wr_bias = 8'sd0;
    tick();
    b_pool_start = 1'b0; b_wr_en = 1'b0;
    cyc = 1;
    chk("pool_busy_rise", 64'(b_pool_busy), 64'd1);
    while (!b_pool_done && cyc < 2000) begin
      if (cyc >= 10 && cyc < 15) begin
        b_wr_en = 1'b1; b_wr_addr = 10'd500; b_wr_data = 8'sd99;
        b_rd_en = 1'b1; b_rd_addr_a = 10'd3; b_pool_start = 1'b1;
      end else begin
        b_wr_en = 1'b0; b_rd_en = 1'b0; b_pool_start = 1'b0;
      end
      tick();
      cyc++;
      if (cyc >= 11 && cyc <= 16) chk("busy_rd_valid", 64'(b_rd_valid), 64'd0);
    end
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_pool_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, seen, v, bias;
    rst = 1'b0;
    b_wr_en = 0; b_wr_ch = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_bias = 0;
    b_pool_start = 0; b_rd_en = 0; b_rd_addr_a = 0; b_rd_addr_b = 0;
    s_wr_en = 0; s_wr_ch = 0; s_wr_addr = 0; s_wr_data = 0; s_wr_bias = 0;
    s_pool_start = 0; s_rd_en = 0; s_rd_addr_a = 0; s_rd_addr_b = 0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++)
        for (int a = 0; a < 784; a++) refm[i][k][a] = 0;

    repeat (2) tick();
    chk("rst.pool_busy", 64'(b_pool_busy), 64'd0);
    chk("rst.pool_done", 64'(b_pool_done), 64'd0);
    chk("rst.rd_valid",  64'(b_rd_valid), 64'd0);
    chk("rst.rd_data_a", b_rd_data_a, 64'd0);
    chk("rst.rd_data_b", b_rd_data_b, 64'd0);
    rst = 1'b1;
    tick();

    // Saturation in both directions, out-of-range store and read.
    b_store(3, 5, 100, 50);
    b_rd(5, 900, "sat_hi");
    chk("sat_hi.ch3", 64'(b_rd_data_a[31:24]), 64'(8'h7F));
    chk("oob_b_zero", b_rd_data_b, 64'd0);
    b_store(3, 5, -100, -50);
    b_rd(5, 900, "sat_lo");
    chk("sat_lo.ch3", 64'(b_rd_data_a[31:24]), 64'(8'h80));
    b_store(0, 800, 33, 0);
    b_rd(800, 1023, "oob");
    chk("oob.a", b_rd_data_a, 64'd0);
    tick();
    chk("rd_valid_drop", 64'(b_rd_valid), 64'd0);

    // wr_en beats rd_en in the same cycle.
    b_wr_en = 1'b1; b_wr_ch = 3'd2; b_wr_addr = 10'd10; b_wr_data = 8'sd20; b_wr_bias = 8'sd1;
    b_rd_en = 1'b1; b_rd_addr_a = 10'd10; b_rd_addr_b = 10'd10;
    tick();
    b_wr_en = 1'b0; b_rd_en = 1'b0;
    refm[0][2][10] = 21;
    chk("prio.rd_dropped", 64'(b_rd_valid), 64'd0);
    b_rd(10, 900, "prio");
    chk("prio.ch2", 64'(b_rd_data_a[23:16]), 64'd21);

    // Fill: ch0 is the addr-mod-100 ramp, other channels random with saturation.
    for (int a = 0; a < 784; a++) begin
      bias = int'($urandom_range(40)) - 20;
      b_store(0, a, (a % 100) - 50 - bias, bias);
      for (int k = 1; k < 8; k++)
        b_store(k, a, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    end
    b_store(1, 2, 7, 0);  b_store(1, 3, 7, 0);  b_store(1, 30, -3, 0); b_store(1, 31, 2, 0);
    b_store(1, 4, -5, 0); b_store(1, 5, -5, 0); b_store(1, 32, -5, 0); b_store(1, 33, -5, 0);
    for (int i = 0; i < 12; i++)
      b_read_full(int'($urandom_range(1023)), int'($urandom_range(1023)), "pre");

    b_pool(cyc);
    chk("pool_latency", 64'(cyc), 64'd981);
    chk("busy_at_done", 64'(b_pool_busy), 64'd0);
    tick();
    chk("done_one_cycle", 64'(b_pool_done), 64'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (b_pool_done) seen++;
    end
    chk("single_pool_done", 64'(seen), 64'd0);
    chk("idle_after_pool", 64'(b_pool_busy), 64'd0);
    model_pool(0, 8, 28, 28);

    b_read_full(0, 195, "dual");
    chk("out0.ch0", 64'(b_rd_data_a[7:0]), 64'(EXP_OUT0));
    b_rd(1, 2, "win");
    chk("out1.ch1_tie", 64'(b_rd_data_a[15:8]), 64'd7);
    chk("out2.ch1_neg", 64'(b_rd_data_b[15:8]), 64'(EXP_NEG5));
    b_read_full(500, 700, "stale");
    for (int o = 0; o < 196; o++)
      b_read_full(o, int'($urandom_range(1023)), "post");

    // Small geometry instance.
    for (int a = 0; a < 64; a++)
      for (int k = 0; k < 4; k++)
        s_store(k, a, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    s_pool_start = 1'b1;
    tick();
    s_pool_start = 1'b0;
    cyc = 1;
    while (!s_pool_done && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("s.pool_latency", 64'(cyc), 64'd81);
    model_pool(1, 4, 8, 8);
    tick();
    for (int o = 0; o < 64; o++) s_read_full(o, 63 - o);

    // Asynchronous reset in the middle of a pool.
    b_pool_start = 1'b1;
    tick();
    b_pool_start = 1'b0;
    repeat (299) tick();
    chk("midpool.busy_before", 64'(b_pool_busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("midpool.busy_rst", 64'(b_pool_busy), 64'd0);
    chk("midpool.done_rst", 64'(b_pool_done), 64'd0);
    chk("midpool.data_rst", b_rd_data_a, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("midpool.idle_after", 64'(b_pool_busy), 64'd0);
    chk("midpool.valid_after", 64'(b_rd_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/fmap_pool_buffer.md
Name: fmap_pool_buffer

Overview:
Parametrised per-channel feature-map buffer between a convolution stage and the next layer.
- Stores conv results with bias add and saturation.
- Performs in-place 2x2/stride-2 max-pooling on all channels in parallel, compacting the pooled map to the bank base.
- Serves two independent read addresses across every channel for the following layer.

Parameters:
NCH, 8, number of output channels / memory banks
DW, 8, signed data width of stored samples and bias
IMG_W, 28, feature-map width in pixels (must be even)
IMG_H, 28, feature-map height in pixels (must be even)
AW, 10, address width; must satisfy 2^AW >= IMG_W*IMG_H

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
wr_en  in  1  store strobe
wr_ch  in  $clog2(NCH)  target channel for store
wr_addr  in  AW  pixel address, row-major r*IMG_W+c
wr_data  in  DW  signed conv result
wr_bias  in  DW  signed bias added before saturation
pool_start  in  1  one-cycle request to pool all channels
pool_busy  out  1  high while pooling
pool_done  out  1  one-cycle pulse when pooling completes
rd_en  in  1  read strobe
rd_addr_a  in  AW  read address A
rd_addr_b  in  AW  read address B
rd_data_a  out  NCH*DW  channel k in bits [k*DW +: DW], from addr A
rd_data_b  out  NCH*DW  same layout, from addr B
rd_valid  out  1  high one cycle after an accepted rd_en

Behaviour:
- Reset values: pool_busy, pool_done, rd_valid, rd_data_a and rd_data_b are 0; FSM returns to IDLE.
- Memory contents are not reset. Reset mid-pool aborts; partially pooled data is undefined.
- Store (IDLE only):
  - Computes sum = wr_data + wr_bias at DW+1 bits.
  - Saturates sum to [-2^(DW-1), 2^(DW-1)-1] and writes it to bank wr_ch at wr_addr on the next edge.
  - The write is ignored if wr_ch >= NCH or wr_addr >= IMG_W*IMG_H.
- Read (IDLE only):
  - rd_en registers bank[k][rd_addr_a] and bank[k][rd_addr_b] for all k; data and rd_valid appear 1 cycle later.
  - An out-of-range address returns 0.
  - Read-during-write to the same address returns the old data.
- Priority in IDLE: pool_start > wr_en > rd_en. Lower-priority strobes in the same cycle are dropped.
- FSM states IDLE -> RD0 -> RD1 -> RD2 -> RD3 -> WR -> (next window: RD0 | last: DONE) -> IDLE.
- pool_start in IDLE sets pool_busy the next cycle and clears the window counters wr_row and wr_col.
- RD0..RD3 read the window pixels at base, base+1, base+IMG_W and base+IMG_W+1, one per cycle.
  - base = 2*wr_row*IMG_W + 2*wr_col.
  - A running signed max is kept per channel; ties keep the earlier pixel.
- WR writes the max, after the optional ReLU, to out = wr_row*(IMG_W/2)+wr_col in every bank.
  - out <= base always, and later windows only read addresses above base, so in-place pooling is safe.
  - Counters advance column-first and wrap at IMG_W/2, then IMG_H/2.
- Cost is 5 cycles per window: (IMG_W/2)*(IMG_H/2)*5 cycles, which is 980 at the default parameters.
- DONE: pool_busy drops and pool_done pulses for 1 cycle; the FSM then returns to IDLE.
- While pool_busy is high, pool_start, wr_en and rd_en are ignored and rd_valid stays 0.
- Addresses at or above (IMG_W/2)*(IMG_H/2) keep their stale pre-pool contents after pooling.

Optional Feature:
POOL_RELU_EN
- Defined: the pooled value is max(window, 0), i.e. negative results are written as 0.
- Undefined: the raw signed window maximum is written, so a later layer can apply its own activation.

Decomposition:
- Package fmap_pkg holds:
  - FSM state enum (IDLE, RD0..RD3, WR, DONE).
  - Function sat_add(a, b) returning a saturated DW-bit sum.
  - Localparams NPIX = IMG_W*IMG_H, OW = IMG_W/2, OH = IMG_H/2.
- One sub-module, fmap_bank: a single-channel DW x NPIX inferred block RAM.
  - Two read ports and one write port.
  - Contains the per-channel running-max register.
  - Instantiated NCH times by a generate loop.

Test Plan:
- Bias saturation: store ch3 addr 5 data 100 bias 50, then read A=5 -> rd_data_a ch3 = 127. Store data -100 bias -50 -> -128.
- Default pool, all banks: fill the bank with pixel value = addr mod 100 - 50, pool -> pool_done pulse exactly 981 cycles after pool_start. Expected out[0] = max(-50,-49,-22,-21) = -21, so 0 with POOL_RELU_EN and -21 without.
- Pool values/tie: window with values {7,7,-3,2} at out[1] -> reads 7. Window with all -5 -> 0 with POOL_RELU_EN, -5 without.
- Pool, ignored strobes: wr_en and rd_en asserted while pool_busy -> memory unchanged and rd_valid stays 0. A second pool_start is ignored, with a single pool_done.
- Dual read: rd_en with A=0 and B=195 after pooling -> both ports return their correct pooled values for all 8 channels, with rd_valid 1 cycle later.
- Reset and parametrisation: assert rst mid-pool at cycle 300 -> pool_busy and pool_done go to 0 immediately. Rerun with NCH=4, IMG_W=IMG_H=8 -> pool_done after 81 cycles with correct compaction to out 0..15.
